fifo_wptr_full: RTL and testbench

Write-side pointer and flag generator for the asynchronous FIFO, running entirely in the write clock domain. It owns the binary and Gray write pointers and supplies the RAM write address. It resynchronises the read-domain Gray pointer through a 2-flop synchroniser and converts it to binary. From that it produces registered full, almost-full and fill-count outputs. Its `wptr_gray` output feeds the read-domain synchroniser and the Gray-to-binary conversion on the read side.

---
 rtl/fifo_wptr_full.sv | 68 ++++++
 tb/tb_fifo_wptr_full.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/flag block of the async FIFO: accepted writes move waddr/wptr_gray and full/count in the same edge.
// Backpressure: wr_accept = wr_en & ~full; read frees become visible 2-3 wclk edges late via the synchroniser.
module fifo_wptr_full #(
  parameter int depth       = 1024,
  parameter int afull_level = depth - 4
) (
  input  logic                       wclk,
  input  logic                       wrst_n,
  input  logic                       wr_en,
  input  logic [$clog2(depth):0]     rptr_gray,
  output logic                       wr_accept,
  output logic [$clog2(depth)-1:0]   waddr,
  output logic [$clog2(depth):0]     wptr_gray,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(depth):0]     wr_count,
  output logic                       wr_overflow
);

  localparam int A = $clog2(depth);
  localparam logic [A:0] afull_thr = (A+1)'(afull_level);

  logic [A:0] wbin;
  logic [A:0] wbin_next;
  logic [A:0] wgray_next;
  logic [A:0] rq1;
  logic [A:0] rq2;
  logic [A:0] rbin_s;
  logic [A:0] count_next;

  assign wr_accept  = wr_en & ~full;
  assign waddr      = wbin[A-1:0];
  assign wbin_next  = wbin + {{A{1'b0}}, wr_accept};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign count_next = wbin_next - rbin_s;

  // Gray-to-binary of the synchronised read pointer.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= A; i++) begin
      rbin_s[i] = ^(rq2 >> i);
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      rq1         <= '0;
      rq2         <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      wr_overflow <= 1'b0;
    end else begin
      rq1         <= rptr_gray;
      rq2         <= rq1;
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      // Full when write Gray equals read Gray with the top two bits inverted.
      full        <= (wgray_next == {~rq2[A:A-1], rq2[A-2:0]});
      almost_full <= (count_next >= afull_thr);
      wr_count    <= count_next;
      wr_overflow <= wr_en & full;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full at depth=16, afull_level=12.
module tb_fifo_wptr_full;

  logic       wclk;
  logic       wrst_n;
  logic       wr_en;
  logic [4:0] rptr_gray;
  logic       wr_accept;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_count;
  logic       wr_overflow;

  fifo_wptr_full #(.depth(16), .afull_level(12)) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .wr_en       (wr_en),
    .rptr_gray   (rptr_gray),
    .wr_accept   (wr_accept),
    .waddr       (waddr),
    .wptr_gray   (wptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .wr_count    (wr_count),
    .wr_overflow (wr_overflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct packed {
    logic       acc;
    logic [3:0] waddr;
    logic [4:0] gray;
    logic       full;
    logic       af;
    logic [4:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: written only by the stimulus process.
  logic [4:0] m_wb   = '0;
  logic       m_full = 1'b0;
  logic [4:0] m_q1   = '0;
  logic [4:0] m_q2   = '0;

  logic       acc_pre   = 1'b0;
  logic [4:0] prev_gray = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // One wclk cycle of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic step(input logic we, input logic [4:0] rg);
    exp_t       e;
    logic       acc;
    logic [4:0] nb;
    logic [4:0] c;
    @(negedge wclk);
    wr_en     = we;
    rptr_gray = rg;
    acc = we & ~m_full;
    nb  = m_wb + {4'b0, acc};
    c   = nb - g2b(m_q2);
    e.acc   = acc;
    e.waddr = nb[3:0];
    e.gray  = b2g(nb);
    e.full  = (c == 5'd16);
    e.af    = (c >= 5'd12);
    e.cnt   = c;
    e.ovf   = we & m_full;
    sb.push_back(e);
    m_wb   = nb;
    m_full = e.full;
    m_q2   = m_q1;
    m_q1   = rg;
  endtask

  task automatic model_reset();
    m_wb   = '0;
    m_full = 1'b0;
    m_q1   = '0;
    m_q2   = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(posedge wclk);
      #2;
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_waddr"}, 32'(waddr), 32'd0);
    chk({tag, "_wptr_gray"}, 32'(wptr_gray), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    chk({tag, "_wr_overflow"}, 32'(wr_overflow), 32'd0);
  endtask

  always @(negedge wclk) begin
    #1;
    acc_pre = wr_accept;
  end

  // Monitor: compares each registered update against the queued expectation.
  always @(posedge wclk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("wr_accept", 32'(acc_pre), 32'(e.acc));
      chk("waddr", 32'(waddr), 32'(e.waddr));
      chk("wptr_gray", 32'(wptr_gray), 32'(e.gray));
      chk("full", 32'(full), 32'(e.full));
      chk("almost_full", 32'(almost_full), 32'(e.af));
      chk("wr_count", 32'(wr_count), 32'(e.cnt));
      chk("wr_overflow", 32'(wr_overflow), 32'(e.ovf));
      chk("gray_one_bit", 32'($countones(wptr_gray ^ prev_gray) <= 1), 32'd1);
    end
    prev_gray = wptr_gray;
  end

  initial begin
    wr_en     = 1'b0;
    rptr_gray = '0;
    wrst_n    = 1'b0;
    #1;
    check_zero("reset");
    @(negedge wclk);
    wrst_n = 1'b1;

    repeat (5) step(1'b0, 5'd0);

    // Fill: almost_full at count 12, full at 16.
    for (int i = 0; i < 16; i++) step(1'b1, 5'd0);
    drain();
    chk("fill_wptr_gray", 32'(wptr_gray), 32'(5'b11000));
    chk("fill_wr_count", 32'(wr_count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_almost_full", 32'(almost_full), 32'd1);

    // Overflow attempts while full.
    repeat (3) step(1'b1, 5'd0);
    step(1'b0, 5'd0);
    drain();
    chk("ovf_waddr", 32'(waddr), 32'd0);
    chk("ovf_wr_count", 32'(wr_count), 32'd16);

    // One read: full drops on the third edge.
    repeat (4) step(1'b0, 5'b00001);
    drain();
    chk("release_full", 32'(full), 32'd0);
    chk("release_wr_count", 32'(wr_count), 32'd15);

    // Wrap-around with the reader trailing four entries behind.
    repeat (3) step(1'b0, b2g(5'd12));
    for (int i = 0; i < 40; i++) step(1'b1, b2g(m_wb - 5'd4));
    drain();
    chk("wrap_waddr", 32'(waddr), 32'd8);
    chk("wrap_wptr_gray", 32'(wptr_gray), 32'(5'b10100));

    // Bring count to 15, then write in the same edge that the read becomes visible.
    repeat (3) step(1'b0, b2g(5'd20));
    repeat (11) step(1'b1, b2g(5'd20));
    drain();
    chk("pre_simul_wr_count", 32'(wr_count), 32'd15);
    repeat (2) step(1'b0, b2g(5'd21));
    step(1'b1, b2g(5'd21));
    drain();
    chk("simul_full", 32'(full), 32'd0);
    chk("simul_wr_count", 32'(wr_count), 32'd15);

    // Asynchronous reset mid-stream with wr_en still high.
    @(negedge wclk);
    #2;
    wrst_n = 1'b0;
    #1;
    check_zero("midreset");
    chk("midreset_wr_accept", 32'(wr_accept), 32'd1);
    wr_en     = 1'b0;
    rptr_gray = '0;
    model_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
    #1;
    chk("post_reset_waddr", 32'(waddr), 32'd0);
    step(1'b1, 5'd0);
    step(1'b0, 5'd0);
    drain();
    chk("post_reset_wr_count", 32'(wr_count), 32'd1);
    chk("post_reset_waddr_next", 32'(waddr), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
